// File: rtl/mem_wb_stage_pkg.sv
// Shared constants, state encoding and store-lane helpers for the memory /
// write-back stage.
package mem_wb_stage_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_CSR    = 7'b1110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_B      = 3'b000;
    localparam logic [2:0] F3_H      = 3'b001;
    localparam logic [2:0] F3_W      = 3'b010;
    localparam logic [2:0] F3_BU     = 3'b100;
    localparam logic [2:0] F3_HU     = 3'b101;
    localparam logic [2:0] F3_CSRRW  = 3'b001;
    localparam logic [2:0] F3_CSRRWI = 3'b101;

    localparam logic [11:0] CSR_TOHOST = 12'h51E;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    typedef enum logic [2:0] {
        CLS_LOAD   = 3'd0,
        CLS_STORE  = 3'd1,
        CLS_JUMP   = 3'd2,
        CLS_CSR    = 3'd3,
        CLS_BRANCH = 3'd4,
        CLS_OTHER  = 3'd5
    } inst_class_e;

    function automatic inst_class_e decode_class(input logic [6:0] opcode);
        inst_class_e cls;
        case (opcode)
            OP_LOAD:         cls = CLS_LOAD;
            OP_STORE:        cls = CLS_STORE;
            OP_JAL, OP_JALR: cls = CLS_JUMP;
            OP_CSR:          cls = CLS_CSR;
            OP_BRANCH:       cls = CLS_BRANCH;
            default:         cls = CLS_OTHER;
        endcase
        return cls;
    endfunction

    // Halfword stores ignore off[0] so a misaligned SH lands on its own half.
    function automatic logic [3:0] store_mask(input logic [2:0] funct3, input logic [1:0] off);
        logic [3:0] mask;
        case (funct3)
            F3_B:    mask = 4'b0001 << off;
            F3_H:    mask = 4'b0011 << {off[1], 1'b0};
            default: mask = 4'b1111;
        endcase
        return mask;
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] funct3, input logic [31:0] data);
        logic [31:0] lanes;
        case (funct3)
            F3_B:    lanes = {4{data[7:0]}};
            F3_H:    lanes = {2{data[15:0]}};
            default: lanes = data;
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/mem_wb_stage_if.sv
// Data-memory request/response bus between the stage and the memory.
interface mem_wb_stage_if;
    logic        dmem_req_valid;
    logic        dmem_req_ready;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_we;
    logic [31:0] dmem_din;
    logic        dmem_resp_valid;
    logic [31:0] dmem_dout;

    modport master (
        output dmem_req_valid, dmem_addr, dmem_we, dmem_din,
        input  dmem_req_ready, dmem_resp_valid, dmem_dout
    );

    modport slave (
        input  dmem_req_valid, dmem_addr, dmem_we, dmem_din,
        output dmem_req_ready, dmem_resp_valid, dmem_dout
    );
endinterface

// File: rtl/mem_wb_stage_load_align.sv
// Picks the addressed byte/half out of a read word and extends it per funct3;
// misaligned halfword offsets fall back to the containing half.
module load_align
    import mem_wb_stage_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] value
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane selection and sign/zero extension.
    always_comb begin
        case (off)
            2'b00:   byte_s = word[7:0];
            2'b01:   byte_s = word[15:8];
            2'b10:   byte_s = word[23:16];
            2'b11:   byte_s = word[31:24];
            default: byte_s = word[7:0];
        endcase
        if (off[1]) begin
            half_s = word[31:16];
        end else begin
            half_s = word[15:0];
        end
        case (funct3)
            F3_B:    value = {{24{byte_s[7]}}, byte_s};
            F3_BU:   value = {24'h000000, byte_s};
            F3_H:    value = {{16{half_s[15]}}, half_s};
            F3_HU:   value = {16'h0000, half_s};
            default: value = word;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory access and write-back stage: issues loads/stores on the dmem bus,
// stalls upstream while a transfer is in flight and produces write-back data.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic [31:0]   pc_in,
    input  logic [31:0]   alu_out_in,
    input  logic [31:0]   rs2d_in,
    input  logic          jump_in,
    input  logic [31:0]   inst_in,
    mem_wb_stage_if.master mem,
    output logic          stall,
    output logic          wb_en,
    output logic [4:0]    wb_rd,
    output logic [31:0]   wb_data,
    output logic          tohost_we,
    output logic [31:0]   tohost_data
);

    state_e      state_r;
    state_e      state_nxt_s;
    logic [31:0] load_q_r;
    logic [31:0] load_val_s;
    inst_class_e cls_s;
    logic [2:0]  funct3_s;
    logic [4:0]  rd_s;
    logic        is_mem_s;
    logic        req_valid_s;
    logic        stall_s;
    logic        capture_s;
    logic        in_idle_s;
    logic        in_done_s;
    logic        writes_rd_s;
    logic        tohost_hit_s;
    // Jumps commit like any other instruction, so jump_in has no effect here.
    logic        unused_s;

    assign unused_s = jump_in;
    assign cls_s    = decode_class(inst_in[6:0]);
    assign funct3_s = inst_in[14:12];
    assign rd_s     = inst_in[11:7];
    assign is_mem_s = (cls_s == CLS_LOAD) || (cls_s == CLS_STORE);

    load_align u_load_align (
        .word   (mem.dmem_dout),
        .off    (alu_out_in[1:0]),
        .funct3 (funct3_s),
        .value  (load_val_s)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Extended load result, held for the completion cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            load_q_r <= 32'h0000_0000;
        end else if (capture_s) begin
            load_q_r <= load_val_s;
        end else begin
            load_q_r <= load_q_r;
        end
    end

    // Next-state and handshake decode; responses outside WAIT are ignored.
    always_comb begin
        state_nxt_s = state_r;
        req_valid_s = 1'b0;
        stall_s     = 1'b0;
        capture_s   = 1'b0;
        in_idle_s   = 1'b0;
        in_done_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                in_idle_s = 1'b1;
                if (is_mem_s) begin
                    req_valid_s = 1'b1;
                    stall_s     = 1'b1;
                    if (mem.dmem_req_ready) begin
                        if (cls_s == CLS_STORE) begin
                            state_nxt_s = ST_DONE;
                        end else begin
                            state_nxt_s = ST_WAIT;
                        end
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                stall_s = 1'b1;
                if (mem.dmem_resp_valid) begin
                    capture_s   = 1'b1;
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_DONE: begin
                in_done_s   = 1'b1;
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Write-back and host-interface decode.
    always_comb begin
        writes_rd_s = (rd_s != 5'd0) && (cls_s != CLS_STORE) &&
                      (cls_s != CLS_BRANCH) && (cls_s != CLS_CSR);
        tohost_hit_s = (cls_s == CLS_CSR) && (inst_in[31:20] == CSR_TOHOST) &&
                       ((funct3_s == F3_CSRRW) || (funct3_s == F3_CSRRWI)) && in_idle_s;
        case (cls_s)
            CLS_JUMP: wb_data = pc_in + 32'd4;
            CLS_LOAD: wb_data = load_q_r;
            default:  wb_data = alu_out_in;
        endcase
        if (funct3_s == F3_CSRRWI) begin
            tohost_data = {27'd0, inst_in[19:15]};
        end else begin
            tohost_data = alu_out_in;
        end
        wb_rd          = rd_s;
        mem.dmem_addr  = {alu_out_in[31:2], 2'b00};
        mem.dmem_din   = store_data(funct3_s, rs2d_in);
        if (reset) begin
            mem.dmem_req_valid = 1'b0;
            mem.dmem_we        = 4'b0000;
            stall              = 1'b0;
            wb_en              = 1'b0;
            tohost_we          = 1'b0;
        end else begin
            mem.dmem_req_valid = req_valid_s;
            if (req_valid_s && (cls_s == CLS_STORE)) begin
                mem.dmem_we = store_mask(funct3_s, alu_out_in[1:0]);
            end else begin
                mem.dmem_we = 4'b0000;
            end
            stall     = stall_s;
            tohost_we = tohost_hit_s;
            if (cls_s == CLS_LOAD) begin
                wb_en = writes_rd_s && in_done_s;
            end else begin
                wb_en = writes_rd_s && in_idle_s;
            end
        end
    end

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, rising edge; reset  in  1  asynchronous, active-high.
REQ-002 SHALL have: pc_in  in  32  PC from the stage-2/3 transfer register; alu_out_in  in  32  ALU result or memory address; rs2d_in  in  32  store data; jump_in  in  1  jump flag; inst_in  in  32  instruction.
REQ-003 SHALL have: dmem_req_valid  out  1; dmem_req_ready  in  1; dmem_addr  out  32  word-aligned; dmem_we  out  4  byte mask, 0 means read; dmem_din  out  32  aligned store data.
REQ-004 SHALL have: dmem_resp_valid  in  1; dmem_dout  in  32  read word.
REQ-005 SHALL have: stall  out  1  freezes upstream stages; wb_en  out  1; wb_rd  out  5; wb_data  out  32; tohost_we  out  1; tohost_data  out  32.

Function
REQ-006 SHALL decode inst_in[6:0] as LOAD 0000011, STORE 0100011, JAL/JALR, CSR 1110011, or other (LUI/AUIPC/OP/OP-IMM/BRANCH).
REQ-007 SHALL use three states: IDLE, WAIT (load outstanding), DONE (one-cycle completion).
REQ-008 IDLE, LOAD/STORE: dmem_req_valid=1, stall=1; on valid&ready, STORE->DONE and LOAD->WAIT; otherwise hold in IDLE with the request stable.
REQ-009 WAIT: dmem_req_valid=0, stall=1; on dmem_resp_valid, capture the extended load value into load_q and go to DONE.
REQ-010 DONE: stall=0, dmem_req_valid=0; unconditionally return to IDLE next cycle.
REQ-011 Non-memory instruction in IDLE: stall=0, no request; write-back outputs are combinational from the inputs.
REQ-012 dmem_addr = {alu_out_in[31:2],2'b00}; byte offset off = alu_out_in[1:0].
REQ-013 Store: SB -> we=4'b0001<<off, din = rs2d_in[7:0] replicated x4; SH -> we=4'b0011<<(off&2), din = rs2d_in[15:0] replicated x2; SW -> we=4'b1111, din=rs2d_in.
REQ-014 Load: LB/LBU select byte off; LH/LHU select half off[1]; sign-extend or zero-extend per funct3; LW passes the word through.
REQ-015 Misaligned LH/LW/SH/SW SHALL be treated as aligned (offset bits ignored for that width); no trap.
REQ-016 wb_rd=inst_in[11:7]; wb_en=0 whenever rd=0, or for STORE/BRANCH/CSR.
REQ-017 wb_data: JAL/JALR -> pc_in+4 (mod 2^32); LOAD -> load_q, valid only in DONE; others -> alu_out_in.
REQ-018 LOAD wb_en SHALL be 1 only in DONE, never in IDLE or WAIT.
REQ-019 CSRRW/CSRRWI with csr=0x51E: tohost_we=1 for one cycle, tohost_data = rs1 value (alu_out_in) or zero-extended uimm; other CSRs ignored.
REQ-020 A dmem_resp_valid arriving in IDLE or DONE SHALL be ignored.
REQ-021 A simultaneous req_ready and resp_valid in IDLE SHALL only accept the request.
REQ-022 jump_in SHALL not gate write-back, because jumps commit.

Reset
REQ-023 reset SHALL force state=IDLE and load_q=0 asynchronously.
REQ-024 During reset, SHALL drive dmem_req_valid=0, dmem_we=0, stall=0, wb_en=0, tohost_we=0.
REQ-025 Reset in WAIT SHALL abandon the load; a late response after reset is dropped per REQ-020.

Structure
REQ-026 A shared package SHALL hold opcode and funct3 constants, CSR_TOHOST=12'h51E, and the state encoding (2 bits).
REQ-027 Load extraction SHALL be one combinational sub-module, load_align (word, off, funct3 -> 32-bit value).
REQ-028 Only state and load_q SHALL be registered; everything else is combinational.

Verification
REQ-029 SW addr 0x104, rs2d=0xDEADBEEF, ready=1 -> one cycle of req with we=1111, addr 0x104, din DEADBEEF; next cycle DONE with stall=0.
REQ-030 LB addr 0x203, dout=0x80xxxxxx, resp after 3 WAIT cycles -> stall high 4 cycles; DONE wb_data=0xFFFFFF80, wb_en=1.
REQ-031 SH addr 0x2, rs2d=0x1234 -> we=1100, din=0x12341234; LHU of same word returning 0x12340000 -> wb_data=0x00001234.
REQ-032 JAL rd=1, pc_in=0xFFFFFFFC -> wb_data=0x00000000, stall=0; rd=0 -> wb_en=0.
REQ-033 Reset asserted in WAIT, then resp_valid -> state IDLE, no wb_en pulse; CSRRW 0x51E, alu_out=1 -> tohost_we=1, tohost_data=1.
